// File: rtl/cla_slice_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cla_slice_sequencer_pkg
//   Shared sizing constants and state encoding for the slice-serial adder
//   sequencers. Other sequencers import the same state type so their state
//   registers decode identically in waveforms and in the FMA control logic.
//
//   DEF_ADDER_WIDTH   : default total operand / sum width
//   DEF_CLA_GRP_WIDTH : default width of one carry-lookahead group
//   DEF_NUM_GRP       : slices per operation for the default sizing
//   seq_state_t       : IDLE=0, RUN=1, DONE=2
// -----------------------------------------------------------------------------
package cla_slice_sequencer_pkg;

   localparam int DEF_ADDER_WIDTH   = 16;
   localparam int DEF_CLA_GRP_WIDTH = 4;
   localparam int DEF_NUM_GRP       = DEF_ADDER_WIDTH / DEF_CLA_GRP_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/ahead_adder.sv
// -----------------------------------------------------------------------------
// ahead_adder
//   One carry-lookahead group. Every internal carry is formed directly from
//   the generate/propagate terms and the group carry-in (sum-of-products),
//   so no carry ripples bit-to-bit inside the group.
//
//   a, b : WIDTH-bit operands
//   cin  : group carry-in
//   s    : WIDTH-bit group sum
//   cout : group carry-out
// -----------------------------------------------------------------------------
module ahead_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   c;
   logic             chain;

   assign g = a & b;
   assign p = a ^ b;

   // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
   always_comb begin
      // NOTE: every variable written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      c     = '0;
      chain = 1'b0;
      c[0]  = cin;
      for (int i = 0; i < WIDTH; i++) begin
         c[i+1] = g[i];
         chain  = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (chain & g[j]);
            chain  = chain & p[j];
         end
         c[i+1] = c[i+1] | (chain & cin);
      end
   end

   assign s    = p ^ c[WIDTH-1:0];
   assign cout = c[WIDTH];

endmodule

// File: rtl/cla_slice_sequencer.sv
// -----------------------------------------------------------------------------
// cla_slice_sequencer
//   Computes {cout,sum} = in1 + in2 + effectiveOp with a single time-shared
//   CLA_GRP_WIDTH-bit ahead_adder, one slice per clock, LSB slice first.
//   The inter-slice carry is held in a register between slices.
//
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : operand request
//   in_ready    : high in IDLE only
//   in1, in2    : ADDER_WIDTH-bit operands
//   effectiveOp : carry-in to slice 0
//   out_valid   : high in DONE only
//   out_ready   : consumer takes the result
//   sum         : registered ADDER_WIDTH-bit result
//   cout        : registered carry-out of the top slice
//   busy        : high in RUN or DONE
// -----------------------------------------------------------------------------
module cla_slice_sequencer
   import cla_slice_sequencer_pkg::*;
#(
   parameter int ADDER_WIDTH   = DEF_ADDER_WIDTH,
   parameter int CLA_GRP_WIDTH = DEF_CLA_GRP_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDER_WIDTH-1:0] in1,
   input  logic [ADDER_WIDTH-1:0] in2,
   input  logic                   effectiveOp,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDER_WIDTH-1:0] sum,
   output logic                   cout,
   output logic                   busy
);

   localparam int NUM_GRP = ADDER_WIDTH / CLA_GRP_WIDTH;
   localparam int CNT_W   = $clog2(NUM_GRP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_GRP - 1);

   seq_state_t state;
   seq_state_t state_nxt;

   logic [ADDER_WIDTH-1:0]   op_a;
   logic [ADDER_WIDTH-1:0]   op_b;
   logic [ADDER_WIDTH-1:0]   acc;
   logic                     carry;
   logic                     cout_q;
   logic [CNT_W-1:0]         cnt;
   logic [CLA_GRP_WIDTH-1:0] slice_sum;
   logic                     slice_cout;

   ahead_adder #(
      .WIDTH (CLA_GRP_WIDTH)
   ) u_slice (
      .a    (op_a[CLA_GRP_WIDTH-1:0]),
      .b    (op_b[CLA_GRP_WIDTH-1:0]),
      .cin  (carry),
      .s    (slice_sum),
      .cout (slice_cout)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values, independent of block order.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------------------------------------------------------------
   // Next state and handshake outputs, decoded purely from state so an
   // output handshake can never coincide with an input accept.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath. The accumulator only moves in RUN, so it is stable in DONE
   // and IDLE and can drive the sum port directly.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a  <= in1;
                  op_b  <= in2;
                  carry <= effectiveOp;
                  cnt   <= '0;
               end
            end
            RUN: begin
               op_a  <= op_a >> CLA_GRP_WIDTH;
               op_b  <= op_b >> CLA_GRP_WIDTH;
               // Each slice result enters at the top; after NUM_GRP shifts
               // slice 0 has reached the bottom and the sum is aligned.
               acc   <= {slice_sum, acc[ADDER_WIDTH-1:CLA_GRP_WIDTH]};
               carry <= slice_cout;
               if (cnt == CNT_LAST) cout_q <= slice_cout;
               else                 cnt    <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign sum  = acc;
   assign cout = cout_q;

endmodule
